spike_aer_encoder: RTL and testbench
====================================

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 96: width of the spike vector consumed from the neuron array.
REQ-002 SHALL have parameter ADDR_W, default 7: width of the emitted neuron address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port spikes_in  input  N_NEURONS  per-timestep spike vector from the neuron array; bit i is neuron i.
REQ-007 SHALL have port spikes_valid  input  1  spikes_in holds a complete timestep.
REQ-008 SHALL have port spikes_ready  output  1  encoder can accept a vector.
REQ-009 SHALL have port aer_addr  output  ADDR_W  address of the spiking neuron; 7'h7F on an end-of-timestep word.
REQ-010 SHALL have port aer_eot  output  1  marks the current word as the end-of-timestep marker.
REQ-011 SHALL have port aer_valid  output  1  aer_addr/aer_eot are valid.
REQ-012 SHALL have port aer_ready  input  1  downstream accepts the current word.
REQ-013 SHALL have port ts_count  output  8  number of completed timesteps, modulo 256.

Function
REQ-014 SHALL implement the states IDLE, SCAN and EOT.
REQ-015 SHALL assert spikes_ready only in IDLE with ena=1.
REQ-016 IDLE: on spikes_valid & spikes_ready, SHALL latch spikes_in into a pending register and go to SCAN if the vector is nonzero, or to EOT if it is zero.
REQ-017 SCAN: SHALL drive aer_valid=1, aer_eot=0, and aer_addr = the index of the lowest set pending bit (priority encode, LSB first).
REQ-018 SCAN: on aer_valid & aer_ready, SHALL clear that pending bit; if no bits remain, SHALL go to EOT in the same cycle.
REQ-019 EOT: SHALL drive aer_valid=1, aer_eot=1, aer_addr=7'h7F; on aer_ready, SHALL increment ts_count (255 wraps to 0) and return to IDLE.
REQ-020 First word SHALL be valid the cycle after the vector is accepted (latency 1).
REQ-021 With aer_ready held high, SHALL emit one word per cycle: k set bits take k+1 cycles including EOT.
REQ-022 While aer_valid=1 and aer_ready=0, aer_addr and aer_eot SHALL hold stable and pending SHALL NOT change.
REQ-023 SHALL NOT drop or duplicate spikes: each set bit SHALL produce exactly one accepted word per timestep.
REQ-024 ena=0 SHALL freeze state, pending, and ts_count, and SHALL force aer_valid=0 and spikes_ready=0; ena returning high SHALL resume from the frozen state.
REQ-025 Bits of spikes_in at index ≥ N_NEURONS do not exist; addresses SHALL lie in 0..N_NEURONS-1 for non-EOT words.
REQ-026 A spikes_valid asserted outside IDLE SHALL be ignored; upstream holds the vector until it sees spikes_ready.

Reset
REQ-027 rst_n low SHALL asynchronously set state=IDLE, pending=0, ts_count=0, aer_valid=0, aer_eot=0, aer_addr=0, and spikes_ready=0 while reset is held.
REQ-028 Reset asserted mid-SCAN or mid-EOT SHALL discard the pending vector with no further words emitted.
REQ-029 After rst_n deasserts with ena=1, spikes_ready SHALL be 1 on the first clock edge.

Verification
REQ-030 Bench SHALL apply spikes_in with bits 0, 5, 95 set and aer_ready=1 -> addresses 0, 5, 95, then EOT 7F, on 4 consecutive cycles; ts_count goes 0->1.
REQ-031 Bench SHALL apply an all-zero vector -> only the EOT word (7F, eot=1), then IDLE.
REQ-032 Bench SHALL apply an all-ones vector (96 bits) -> addresses 0..95 in order, then EOT; 97 handshakes total.
REQ-033 Bench SHALL apply bits 3 and 7 set and hold aer_ready=0 for 5 cycles -> addr 3 stable for all 5 cycles, then 3, 7, 7F once aer_ready is released.
REQ-034 Bench SHALL run 256 empty timesteps -> ts_count wraps to 0; then assert rst_n low mid-SCAN -> aer_valid=0 immediately and ts_count=0.
REQ-035 Bench SHALL drop ena low for 3 cycles during SCAN -> aer_valid=0 with state frozen, and emission resumes at the same address once ena returns high.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// Converts a per-timestep spike vector into a stream of AER words: one address
// per set bit (lowest index first), followed by an end-of-timestep marker.
module spike_aer_encoder #(
  parameter int unsigned N_NEURONS = 96,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spikes_in,
  input  logic                 spikes_valid,
  output logic                 spikes_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic                 aer_eot,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [7:0]           ts_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EOT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [N_NEURONS-1:0] pending_rest;
  logic [7:0]           ts_count_q, ts_count_d;
  logic [ADDR_W-1:0]    low_idx;
  logic                 low_found;
  logic                 accept;
  logic                 word_fire;

  // Lowest set pending bit wins.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (pending_q[i] && !low_found) begin
        low_idx   = ADDR_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit without needing the encoder output.
  assign pending_rest = pending_q & (pending_q - N_NEURONS'(1));

  always_comb begin
    spikes_ready = rst_n & ena & (state_q == S_IDLE);
    aer_valid    = ena & ((state_q == S_SCAN) | (state_q == S_EOT));
    aer_eot      = (state_q == S_EOT);
    aer_addr     = '0;
    if (state_q == S_EOT) begin
      aer_addr = '1;
    end else if (state_q == S_SCAN) begin
      aer_addr = low_idx;
    end
  end

  assign accept    = spikes_valid & spikes_ready;
  assign word_fire = aer_valid & aer_ready;
  assign ts_count  = ts_count_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ts_count_d = ts_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pending_d = spikes_in;
          state_d   = (|spikes_in) ? S_SCAN : S_EOT;
        end
      end
      S_SCAN: begin
        if (pending_q == '0) begin
          state_d = S_EOT;
        end else if (word_fire) begin
          pending_d = pending_rest;
          if (pending_rest == '0) begin
            state_d = S_EOT;
          end
        end
      end
      S_EOT: begin
        if (word_fire) begin
          ts_count_d = ts_count_q + 8'd1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      ts_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ts_count_q <= ts_count_d;
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: directed and randomized timesteps
// compared against a word-list model of the expected AER stream.
module tb_spike_aer_encoder;

  localparam int unsigned N  = 96;
  localparam int unsigned AW = 7;
  localparam int unsigned EOT_WORD = 256 + 127;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [N-1:0]  spikes_in = '0;
  logic          spikes_valid = 1'b0;
  logic          spikes_ready;
  logic [AW-1:0] aer_addr;
  logic          aer_eot;
  logic          aer_valid;
  logic          aer_ready = 1'b0;
  logic [7:0]    ts_count;

  int checks = 0;
  int failures = 0;
  int unsigned exp_ts = 0;

  // Words are encoded as address, plus 256 when the word is an EOT marker.
  int unsigned exp_words[$];
  int unsigned got_words[$];
  int unsigned got_cycles;
  bit          got_done;

  always #5 clk = ~clk;

  spike_aer_encoder #(
    .N_NEURONS(N),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .spikes_in   (spikes_in),
    .spikes_valid(spikes_valid),
    .spikes_ready(spikes_ready),
    .aer_addr    (aer_addr),
    .aer_eot     (aer_eot),
    .aer_valid   (aer_valid),
    .aer_ready   (aer_ready),
    .ts_count    (ts_count)
  );

  function automatic void build_expected(input logic [N-1:0] v);
    exp_words.delete();
    for (int i = 0; i < N; i++) if (v[i]) exp_words.push_back(i);
    exp_words.push_back(EOT_WORD);
  endfunction

  function automatic int unsigned cur_word();
    int unsigned w;
    w = 32'(aer_addr);
    if (aer_eot) w += 256;
    return w;
  endfunction

  task automatic send_vector(input logic [N-1:0] v, output bit ok);
    int unsigned cyc;
    cyc = 0;
    @(negedge clk);
    spikes_in = v;
    spikes_valid = 1'b1;
    #1;
    while (!spikes_ready && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    ok = spikes_ready;
    @(negedge clk);
    spikes_valid = 1'b0;
    spikes_in = '0;
  endtask

  task automatic collect(input int unsigned max_cyc);
    got_words.delete();
    got_done = 1'b0;
    got_cycles = 0;
    while (!got_done && got_cycles < max_cyc) begin
      aer_ready = 1'b1;
      #1;
      got_cycles++;
      if (aer_valid && aer_ready) begin
        got_words.push_back(cur_word());
        if (aer_eot) got_done = 1'b1;
      end
      @(negedge clk);
    end
    aer_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", aer_valid); end
    checks++; if (aer_eot !== 1'b0) begin failures++; $display("FAIL reset_eot got=%0b exp=0", aer_eot); end
    checks++; if (aer_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", aer_addr); end
    checks++; if (spikes_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", spikes_ready); end
    checks++; if (ts_count !== 8'd0) begin failures++; $display("FAIL reset_ts got=%0d exp=0", ts_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (spikes_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", spikes_ready); end
    exp_ts = 0;
  endtask

  task automatic test_directed(input string name, input logic [N-1:0] v);
    bit ok;
    build_expected(v);
    send_vector(v, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL %s_accept got=%0b exp=1", name, ok); end
    collect(300);
    checks++; if (got_done !== 1'b1) begin failures++; $display("FAIL %s_eot_seen got=%0b exp=1", name, got_done); end
    checks++; if (got_words.size() != exp_words.size()) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, got_words.size(), exp_words.size()); end
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
      checks++;
      if (got_words[i] != exp_words[i]) begin failures++; $display("FAIL %s_word%0d got=%0d exp=%0d", name, i, got_words[i], exp_words[i]); end
    end
    checks++; if (got_cycles != exp_words.size()) begin failures++; $display("FAIL %s_cycles got=%0d exp=%0d", name, got_cycles, exp_words.size()); end
    if (got_done) exp_ts = (exp_ts + 1) % 256;
    #1;
    checks++; if (ts_count !== 8'(exp_ts)) begin failures++; $display("FAIL %s_ts got=%0d exp=%0d", name, ts_count, exp_ts); end
    checks++; if (aer_valid !== 1'b0 || spikes_ready !== 1'b1) begin failures++; $display("FAIL %s_idle got=%0b%0b exp=01", name, aer_valid, spikes_ready); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] v;
    bit ok;
    v = '0; v[3] = 1'b1; v[7] = 1'b1;
    build_expected(v);
    send_vector(v, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_accept got=%0b exp=1", ok); end
    aer_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (aer_valid !== 1'b1 || aer_addr !== 7'd3 || aer_eot !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got=v%0b a%0d e%0b exp=v1 a3 e0", k, aer_valid, aer_addr, aer_eot);
      end
      @(negedge clk);
    end
    collect(20);
    checks++; if (got_words.size() != exp_words.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_words.size(), exp_words.size()); end
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
      checks++;
      if (got_words[i] != exp_words[i]) begin failures++; $display("FAIL bp_word%0d got=%0d exp=%0d", i, got_words[i], exp_words[i]); end
    end
    checks++; if (got_cycles != 3) begin failures++; $display("FAIL bp_cycles got=%0d exp=3", got_cycles); end
    if (got_done) exp_ts = (exp_ts + 1) % 256;
    #1;
    checks++; if (ts_count !== 8'(exp_ts)) begin failures++; $display("FAIL bp_ts got=%0d exp=%0d", ts_count, exp_ts); end
  endtask

  task automatic test_ts_wrap_and_reset();
    logic [N-1:0] v;
    bit ok;
    for (int t = 0; t < 256; t++) begin
      send_vector('0, ok);
      collect(20);
      if (got_done) exp_ts = (exp_ts + 1) % 256;
      #1;
      checks++;
      if (got_words.size() != 1 || got_words[0] != EOT_WORD) begin
        failures++; $display("FAIL wrap_eot_only t=%0d got_n=%0d exp_n=1", t, got_words.size());
      end
      checks++;
      if (ts_count !== 8'(exp_ts)) begin failures++; $display("FAIL wrap_ts t=%0d got=%0d exp=%0d", t, ts_count, exp_ts); end
    end
    v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
    send_vector(v, ok);
    aer_ready = 1'b1;
    #1;
    checks++; if (aer_valid !== 1'b1 || aer_addr !== 7'd10) begin failures++; $display("FAIL rst_scan_first got=v%0b a%0d exp=v1 a10", aer_valid, aer_addr); end
    @(negedge clk);
    #1;
    checks++; if (aer_addr !== 7'd20) begin failures++; $display("FAIL rst_scan_second got=%0d exp=20", aer_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_ts = 0;
    checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", aer_valid); end
    checks++; if (ts_count !== 8'd0) begin failures++; $display("FAIL rst_mid_ts got=%0d exp=0", ts_count); end
    checks++; if (spikes_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=%0b exp=0", spikes_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL rst_discard%0d got=%0b exp=0", k, aer_valid); end
      @(negedge clk);
    end
    aer_ready = 1'b0;
  endtask

  task automatic test_ena_freeze();
    logic [N-1:0] v;
    bit ok;
    v = '0; v[2] = 1'b1; v[9] = 1'b1; v[40] = 1'b1;
    send_vector(v, ok);
    aer_ready = 1'b1;
    #1;
    checks++; if (aer_valid !== 1'b1 || aer_addr !== 7'd2) begin failures++; $display("FAIL ena_first got=v%0b a%0d exp=v1 a2", aer_valid, aer_addr); end
    @(negedge clk);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (aer_valid !== 1'b0 || spikes_ready !== 1'b0) begin failures++; $display("FAIL ena_off%0d got=v%0b r%0b exp=v0 r0", k, aer_valid, spikes_ready); end
      checks++; if (ts_count !== 8'(exp_ts)) begin failures++; $display("FAIL ena_off_ts%0d got=%0d exp=%0d", k, ts_count, exp_ts); end
      @(negedge clk);
    end
    ena = 1'b1;
    #1;
    checks++; if (aer_valid !== 1'b1 || aer_addr !== 7'd9) begin failures++; $display("FAIL ena_resume got=v%0b a%0d exp=v1 a9", aer_valid, aer_addr); end
    collect(20);
    checks++;
    if (got_words.size() != 3 || got_words[0] != 9 || got_words[1] != 40 || got_words[2] != EOT_WORD) begin
      failures++; $display("FAIL ena_rest got_n=%0d exp=9,40,EOT", got_words.size());
    end
    if (got_done) exp_ts = (exp_ts + 1) % 256;
    #1;
    checks++; if (ts_count !== 8'(exp_ts)) begin failures++; $display("FAIL ena_ts got=%0d exp=%0d", ts_count, exp_ts); end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    bit ok;
    bit done;
    bit stalled;
    int unsigned cyc;
    int unsigned prev_word;
    for (int t = 0; t < 25; t++) begin
      v = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = v & {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
        2: v = v | {$urandom, $urandom, $urandom};
        default: ;
      endcase
      build_expected(v);
      send_vector(v, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rnd_accept t=%0d got=%0b exp=1", t, ok); end
      got_words.delete();
      done = 1'b0; stalled = 1'b0; cyc = 0; prev_word = 0;
      while (!done && cyc < 2000) begin
        aer_ready = 1'($urandom_range(0, 1));
        ena = ($urandom_range(0, 7) != 0);
        spikes_valid = 1'b1;
        spikes_in = {$urandom, $urandom, $urandom};
        #1;
        cyc++;
        if (!ena) begin
          checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL rnd_ena_gate t=%0d got=%0b exp=0", t, aer_valid); end
        end
        if (aer_valid) begin
          if (stalled) begin
            checks++;
            if (cur_word() != prev_word) begin failures++; $display("FAIL rnd_stable t=%0d got=%0d exp=%0d", t, cur_word(), prev_word); end
          end
          prev_word = cur_word();
          stalled = !aer_ready;
          if (aer_ready) begin
            got_words.push_back(cur_word());
            if (aer_eot) done = 1'b1;
          end
        end
        @(negedge clk);
      end
      spikes_valid = 1'b0; spikes_in = '0; ena = 1'b1; aer_ready = 1'b0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL rnd_timeout t=%0d got=%0b exp=1", t, done); end
      checks++; if (got_words.size() != exp_words.size()) begin failures++; $display("FAIL rnd_count t=%0d got=%0d exp=%0d", t, got_words.size(), exp_words.size()); end
      for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
        checks++;
        if (got_words[i] != exp_words[i]) begin failures++; $display("FAIL rnd_word t=%0d i=%0d got=%0d exp=%0d", t, i, got_words[i], exp_words[i]); end
      end
      if (done) exp_ts = (exp_ts + 1) % 256;
      #1;
      checks++; if (ts_count !== 8'(exp_ts)) begin failures++; $display("FAIL rnd_ts t=%0d got=%0d exp=%0d", t, ts_count, exp_ts); end
    end
  endtask

  initial begin
    logic [N-1:0] v;
    test_reset();
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[95] = 1'b1;
    test_directed("three_bits", v);
    test_directed("all_zero", '0);
    test_directed("all_ones", '1);
    test_backpressure();
    test_ts_wrap_and_reset();
    test_ena_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
